// File: rtl/door_sequencer.sv
// door_sequencer: elevator car door FSM. Opens on arrival or request, dwells,
// closes, and reopens on obstruction, request or overweight. Outputs are
// registered and decoded from the state being entered.
module door_sequencer #(
  parameter int OPEN_TIME  = 4,
  parameter int HOLD_TIME  = 20,
  parameter int CLOSE_TIME = 4,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic weight_flip_reset,
  input  logic arrive,
  input  logic open_btn,
  input  logic close_btn,
  input  logic obstruction,
  input  logic weight_limit_exceeded,
  output logic door,
  output logic door_closed,
  output logic motor_open,
  output logic motor_close,
  output logic overload_alarm
);

  typedef enum logic [2:0] {CLOSED, OPENING, OPEN, CLOSING, OVERLOAD} state_t;

  localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_TIME - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_TIME - 1);
  localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(CLOSE_TIME - 1);

  state_t           state, nxt;
  logic             restart;
  logic [CNT_W-1:0] timer;

  // Next-state selection; the if/else order encodes weight > open > close > timer.
  always_comb begin
    nxt     = state;
    restart = 1'b0;
    case (state)
      CLOSED:   if (arrive || open_btn) nxt = OPENING;
      OPENING:  if (timer == OPEN_LAST) nxt = OPEN;
      OPEN: begin
        if (weight_limit_exceeded)          nxt = OVERLOAD;
        else if (open_btn || obstruction)   restart = 1'b1;
        else if (close_btn)                 nxt = CLOSING;
        else if (timer == HOLD_LAST)        nxt = CLOSING;
      end
      CLOSING: begin
        if (weight_limit_exceeded || obstruction || open_btn) nxt = OPENING;
        else if (timer == CLOSE_LAST)                         nxt = CLOSED;
      end
      OVERLOAD: if (!weight_limit_exceeded) nxt = OPEN;
      default:  nxt = CLOSED;
    endcase
  end

  // State, dwell timer and registered Moore outputs. CLOSED and OVERLOAD are
  // untimed, so the timer is parked at 0 there to avoid wrapping.
  always_ff @(posedge clk or posedge weight_flip_reset) begin
    if (weight_flip_reset) begin
      state          <= CLOSED;
      timer          <= '0;
      door           <= 1'b0;
      door_closed    <= 1'b1;
      motor_open     <= 1'b0;
      motor_close    <= 1'b0;
      overload_alarm <= 1'b0;
    end else begin
      state          <= nxt;
      timer          <= (nxt != state || restart || nxt == CLOSED || nxt == OVERLOAD)
                        ? '0 : timer + CNT_W'(1);
      door           <= (nxt != CLOSED);
      door_closed    <= (nxt == CLOSED);
      motor_open     <= (nxt == OPENING);
      motor_close    <= (nxt == CLOSING);
      overload_alarm <= (nxt == OVERLOAD);
    end
  end

endmodule
